avg_speed_calc: RTL
===================

Name: avg_speed_calc

Overview:
Parametrised successor to the average-speed block. It holds its own sequential restoring divider, so it no longer drives an external shared divider.
- Computes trip average speed from distance and trip time.
- Auto-selects between the seconds and minutes time bases.
- Saturates the result to a display limit and flags divide-by-zero and overflow.
- Sits between the trip accumulators and the display mux; the top-level controller issues start pulses.

Parameters:
WIDTH_DIST, 16, trip_distance width
WIDTH_TIME, 13, trip_time_sec / trip_time_min width
WIDTH_OUT, 12, avg_speed width
SAT_MAX, 999, saturation ceiling for avg_speed (must fit WIDTH_OUT)
CONST_SEC, 3600, distance scale when seconds base used
CONST_MIN, 60, distance scale when minutes base used
SEC_LIMIT, 6000, trip_time_sec below this selects seconds base

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  block enable; low aborts any operation
start  in  1  single-cycle request for a new average
trip_time_sec  in  WIDTH_TIME  trip time, seconds
trip_time_min  in  WIDTH_TIME  trip time, minutes
trip_distance  in  WIDTH_DIST  trip distance
busy  out  1  computation in progress
avg_speed  out  WIDTH_OUT  saturated quotient
valid  out  1  avg_speed holds a fresh result
overflow  out  1  last quotient exceeded SAT_MAX
div_zero  out  1  last selected divisor was 0

Behaviour:
- Derived width: WD = WIDTH_DIST + clog2(CONST_SEC + 1). With defaults, WD = 28. Dividend, quotient and remainder are WD bits; no truncation before saturation.
- Reset (rst_n low, asynchronous): state IDLE; avg_speed=0; valid=0; busy=0; overflow=0; div_zero=0; divider registers cleared. Reset mid-divide discards the operation.
- States: IDLE, LOAD, DIVIDE, DONE.
- IDLE: if en=1 and start=1, capture operands in this cycle:
  - sel_sec = (trip_time_sec < SEC_LIMIT).
  - dividend = trip_distance*(sel_sec ? CONST_SEC : CONST_MIN).
  - divisor = sel_sec ? trip_time_sec : trip_time_min.
  - Clear valid, set busy, go to LOAD.
- LOAD (1 cycle): if divisor==0, go to DONE with the zero flag set. Otherwise initialise remainder=0 and bit counter=WD-1, then go to DIVIDE.
- DIVIDE: restoring algorithm, one quotient bit per cycle, MSB first. Exactly WD cycles; after counter reaches 0, go to DONE.
- DONE (1 cycle), sets the outputs, clears busy, returns to IDLE:
  - Divide by zero: avg_speed=0, div_zero=1, overflow=0.
  - Quotient > SAT_MAX: avg_speed=SAT_MAX, overflow=1, div_zero=0.
  - Otherwise: avg_speed=quotient[WIDTH_OUT-1:0], both flags 0.
  - In all cases valid=1.
- Latency, with start sampled at edge 0:
  - Normal: valid rises after edge WD+2 (30 with defaults).
  - Divide by zero: valid rises after edge 2.
- valid is a level signal. It stays high until the next accepted start, en=0, or reset.
- avg_speed and the flags hold until the next DONE.
- start while busy=1: ignored, no queuing, the current computation is unaffected.
- start with en=0: ignored.
- en=0 in any state:
  - Next edge: state IDLE, busy=0, valid=0.
  - avg_speed, overflow and div_zero hold their last values.
  - A partial computation is discarded.
- Operands are captured at start. Input changes during busy have no effect.
- Remainder is exact; the quotient floors (no rounding).

Decomposition:
- Shared package: state enum (IDLE/LOAD/DIVIDE/DONE), WD derivation function (clog2-based), default constants CONST_SEC, CONST_MIN, SEC_LIMIT, SAT_MAX.
- One natural sub-module: seq_restoring_div.
  - Parameter WD.
  - Ports: clk, rst_n, load, dividend, divisor, done, quotient, remainder.
  - Reusable by the other trip statistics blocks.
- The FSM, operand selection and saturation stay in avg_speed_calc.

Test Plan:
- Seconds base: dist=100, sec=3600, min=60, en=1, start pulse -> busy high 30 cycles; avg_speed=100, valid=1 after edge 30, overflow=0, div_zero=0.
- Minutes base: dist=500, sec=7200, min=120 -> sel_sec=0, dividend 30000/120 -> avg_speed=250, valid=1.
- Saturation: dist=10000, sec=10 -> quotient 3,600,000 -> avg_speed=999, overflow=1, valid=1.
- Divide by zero: dist=50, sec=0 -> valid after edge 2, avg_speed=0, div_zero=1, busy low from edge 2.
- Handshake abuse:
  - Second start at cycle 5 of a busy divide -> ignored, result unchanged.
  - en dropped at cycle 10 -> next edge busy=0, valid=0, avg_speed retains its prior value.
- Reset mid-operation: rst_n low asynchronously at cycle 15 -> immediate busy=0, valid=0, avg_speed=0, flags 0. After release, a fresh start with dist=100, sec=3600 yields 100.

Source files
------------

// File: rtl/avg_speed_calc_pkg.sv
// Shared definitions for the trip average-speed block.
// Holds the controller state encoding, default scaling constants and the
// helper that derives the internal dividend/quotient width.
package avg_speed_calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH_DIST = 16;
  localparam int DEF_WIDTH_TIME = 13;
  localparam int DEF_WIDTH_OUT  = 12;
  localparam int DEF_SAT_MAX    = 999;
  localparam int DEF_CONST_SEC  = 3600;
  localparam int DEF_CONST_MIN  = 60;
  localparam int DEF_SEC_LIMIT  = 6000;

  // Width needed to hold distance * CONST_SEC without loss. CONST_SEC is the
  // larger of the two scale factors, so it bounds the dividend.
  function automatic int calc_wd(input int width_dist, input int const_sec);
    return width_dist + $clog2(const_sec + 1);
  endfunction

endpackage

// File: rtl/avg_speed_calc_if.sv
// Request/result bundle between the trip controller and avg_speed_calc.
// master: controller side (drives en/start/operands, reads results).
// slave : avg_speed_calc side.
// Signals:
//   en, start                   block enable and single-cycle request
//   trip_time_sec/min           trip time in seconds / minutes
//   trip_distance               trip distance
//   busy, valid                 computation in progress / fresh result level
//   avg_speed                   saturated average speed
//   overflow, div_zero          result flags of the last computation
interface avg_speed_calc_if
  import avg_speed_calc_pkg::*;
#(
  parameter int WIDTH_DIST = DEF_WIDTH_DIST,
  parameter int WIDTH_TIME = DEF_WIDTH_TIME,
  parameter int WIDTH_OUT  = DEF_WIDTH_OUT
) ();

  logic                  en;
  logic                  start;
  logic [WIDTH_TIME-1:0] trip_time_sec;
  logic [WIDTH_TIME-1:0] trip_time_min;
  logic [WIDTH_DIST-1:0] trip_distance;
  logic                  busy;
  logic [WIDTH_OUT-1:0]  avg_speed;
  logic                  valid;
  logic                  overflow;
  logic                  div_zero;

  modport master (
    output en, start, trip_time_sec, trip_time_min, trip_distance,
    input  busy, avg_speed, valid, overflow, div_zero
  );

  modport slave (
    input  en, start, trip_time_sec, trip_time_min, trip_distance,
    output busy, avg_speed, valid, overflow, div_zero
  );

endinterface

// File: rtl/avg_speed_calc_seq_restoring_div.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// A load pulse captures dividend and divisor; WD clocks later the quotient
// and remainder registers hold the exact floor quotient and remainder.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture operands and restart
//   dividend, divisor   WD-bit unsigned operands
//   done                high in the cycle whose closing edge retires the last
//                       quotient bit; results are final after that edge
//   quotient, remainder WD-bit results
// A zero divisor is not trapped here; callers screen it before loading.
module seq_restoring_div #(
  parameter int WD = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [WD-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          done,
  output logic [WD-1:0] quotient,
  output logic [WD-1:0] remainder
);

  localparam int CW = (WD > 1) ? $clog2(WD) : 1;

  logic [WD-1:0] rem_q;
  logic [WD-1:0] quo_q;
  logic [WD-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  // Partial remainder shifted left with the next dividend bit brought in.
  // The quotient register doubles as the dividend shift register.
  logic [WD:0] trial;
  logic [WD:0] diff;
  logic        fits;

  assign trial = {rem_q, quo_q[WD-1]};
  assign diff  = trial - {1'b0, div_q};
  assign fits  = (trial >= {1'b0, div_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
      cnt_q <= CW'(WD - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= fits ? diff[WD-1:0] : trial[WD-1:0];
      quo_q <= {quo_q[WD-2:0], fits};
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign done      = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/avg_speed_calc.sv
// Trip average-speed calculator.
// On an accepted start it picks the seconds base when trip_time_sec is below
// SEC_LIMIT (finer resolution), else the minutes base, scales the distance,
// divides by the selected time with an internal restoring divider and
// presents the floor quotient saturated to SAT_MAX.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    avg_speed_calc_if slave: en/start/operands in, busy/avg_speed/
//          valid/overflow/div_zero out (all outputs registered)
module avg_speed_calc
  import avg_speed_calc_pkg::*;
#(
  parameter int WIDTH_DIST = DEF_WIDTH_DIST,
  parameter int WIDTH_TIME = DEF_WIDTH_TIME,
  parameter int WIDTH_OUT  = DEF_WIDTH_OUT,
  parameter int SAT_MAX    = DEF_SAT_MAX,
  parameter int CONST_SEC  = DEF_CONST_SEC,
  parameter int CONST_MIN  = DEF_CONST_MIN,
  parameter int SEC_LIMIT  = DEF_SEC_LIMIT
) (
  input logic             clk,
  input logic             rst_n,
  avg_speed_calc_if.slave bus
);

  localparam int          WD          = calc_wd(WIDTH_DIST, CONST_SEC);
  localparam logic [31:0] SEC_LIMIT_U = 32'(SEC_LIMIT);

  function automatic logic [WIDTH_OUT-1:0] sat_speed(input logic [WD-1:0] q);
    if (q > WD'(SAT_MAX)) begin
      return WIDTH_OUT'(SAT_MAX);
    end
    return q[WIDTH_OUT-1:0];
  endfunction

  function automatic logic exceeds_max(input logic [WD-1:0] q);
    return (q > WD'(SAT_MAX));
  endfunction

  state_t               state_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [WIDTH_OUT-1:0] avg_q;
  logic                 ovf_q;
  logic                 dz_q;
  logic                 zero_q;

  logic [WD-1:0]        dividend_q;
  logic [WD-1:0]        divisor_q;

  logic                 accept;
  logic                 sel_sec;
  logic [WD-1:0]        dividend_nx;
  logic [WD-1:0]        divisor_nx;

  logic                 div_load;
  logic                 div_done;
  logic [WD-1:0]        quotient;
  logic [WD-1:0]        div_rem_unused;

  assign accept = bus.en && bus.start && (state_q == IDLE);

  // Operand selection, evaluated combinationally and captured at accept.
  assign sel_sec     = (32'(bus.trip_time_sec) < SEC_LIMIT_U);
  assign dividend_nx = WD'(bus.trip_distance) *
                       (sel_sec ? WD'(CONST_SEC) : WD'(CONST_MIN));
  assign divisor_nx  = sel_sec ? WD'(bus.trip_time_sec) : WD'(bus.trip_time_min);

  // Operands are held for the whole computation so input changes while
  // busy have no effect. They are data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dividend_q <= dividend_nx;
      divisor_q  <= divisor_nx;
    end
  end

  assign div_load = (state_q == LOAD) && bus.en && (divisor_q != '0);

  seq_restoring_div #(
    .WD (WD)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (dividend_q),
    .divisor   (divisor_q),
    .done      (div_done),
    .quotient  (quotient),
    .remainder (div_rem_unused)
  );

  // Controller. After an en=0 abort the divider may still be stepping
  // through a stale operation; its done is only looked at in DIVIDE, and
  // the next LOAD restarts it, so the stale run is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!bus.en) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          zero_q  <= (divisor_q == '0);
          state_q <= (divisor_q == '0) ? DONE : DIVIDE;
        end
        DIVIDE: begin
          if (div_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (zero_q) begin
            avg_q <= '0;
            dz_q  <= 1'b1;
            ovf_q <= 1'b0;
          end else begin
            avg_q <= sat_speed(quotient);
            ovf_q <= exceeds_max(quotient);
            dz_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.avg_speed = avg_q;
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;

endmodule
